// File: rtl/pe_loader_pkg.sv
// pe_loader_pkg: shared defaults and FSM state encoding for the PE loader
package pe_loader_pkg;
  localparam int N_IN_DEF = 62;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {IDLE, LOAD, EVAL, HOLD} state_t;
endpackage

// File: rtl/pe_loader.sv
// pe_loader: gathers streamed act/weight beats into zero-padded PE slots and captures the PE result
module pe_loader
  import pe_loader_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int DW = DW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DW-1:0]      s_act,
  input  logic [DW-1:0]      s_wgt,
  input  logic [DW-1:0]      s_bias,
  input  logic               s_last,
  output logic [N_IN*DW-1:0] pe_in,
  output logic [N_IN*DW-1:0] pe_weight,
  output logic [DW-1:0]      pe_bias,
  input  logic [DW-1:0]      pe_out,
  output logic               r_valid,
  input  logic               r_ready,
  output logic [DW-1:0]      r_data,
  output logic               r_trunc,
  output logic               busy
);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  state_t state, nxt;
  logic [IW-1:0] idx, slot;
  logic [N_IN-1:0][DW-1:0] act_q, wgt_q;
  logic wr, at_end, take;
  assign s_ready = (state == IDLE) || (state == LOAD);
  assign busy = state != IDLE;
  assign slot = (state == IDLE) ? '0 : idx;
  assign wr = s_valid && s_ready;
  assign at_end = slot == IW'(N_IN - 1);
  assign take = (state == HOLD) && r_ready;
  assign pe_in = act_q;
  assign pe_weight = wgt_q;
  always_comb begin
    nxt = state;
    if (wr) nxt = (s_last || at_end) ? EVAL : LOAD;
    if (state == EVAL) nxt = HOLD;
    if (take) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // idx holds at the last slot so it never wraps past N_IN-1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      act_q <= '0;
      wgt_q <= '0;
      pe_bias <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_trunc <= 1'b0;
    end else begin
      if (wr) begin
        act_q[slot] <= s_act;
        wgt_q[slot] <= s_wgt;
        idx <= at_end ? slot : slot + IW'(1);
        r_trunc <= at_end && !s_last;
      end
      if (wr && state == IDLE) pe_bias <= s_bias;
      if (state == EVAL) begin
        r_data <= pe_out;
        r_valid <= 1'b1;
      end
      if (take) begin
        idx <= '0;
        act_q <= '0;
        wgt_q <= '0;
        pe_bias <= '0;
        r_valid <= 1'b0;
        r_trunc <= 1'b0;
      end
    end
endmodule

// File: doc/pe_loader.md
PE_LOADER -- requirements
Module: pe_loader

Interface
REQ-001 SHALL have parameter N_IN, default 62, number of activation/weight slots presented to the PE.
REQ-002 SHALL have parameter DW, default 8, sign-magnitude element width (bit DW-1 = sign, bits DW-2:0 = magnitude).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_valid  input  1  input beat valid.
REQ-006 s_ready  output  1  loader accepts a beat.
REQ-007 s_act  input  DW  activation element.
REQ-008 s_wgt  input  DW  weight element.
REQ-009 s_bias  input  DW  bias; sampled on the first beat of a vector only.
REQ-010 s_last  input  1  final beat of the vector.
REQ-011 pe_in  output  N_IN*DW  packed activations to PE; slot k at bits [k*DW +: DW].
REQ-012 pe_weight  output  N_IN*DW  packed weights to PE, same slot layout.
REQ-013 pe_bias  output  DW  bias to PE.
REQ-014 pe_out  input  DW  PE combinational result.
REQ-015 r_valid  output  1  result valid.
REQ-016 r_ready  input  1  result consumer ready.
REQ-017 r_data  output  DW  captured PE result.
REQ-018 r_trunc  output  1  vector ended by slot-count limit without s_last.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, EVAL, HOLD.
REQ-021 Beat accepted when s_valid && s_ready; s_ready = 1 in IDLE and LOAD, 0 in EVAL and HOLD.
REQ-022 IDLE: accepted beat writes slot 0, latches s_bias into pe_bias, sets index to 1 -> LOAD; with s_last on that beat -> EVAL directly.
REQ-023 LOAD: accepted beat writes slot[index], index increments; s_last -> EVAL; no beat leaves state unchanged.
REQ-024 Beat writing slot N_IN-1 SHALL end the vector -> EVAL; r_trunc latched = !s_last on that beat.
REQ-025 Unwritten slots SHALL read as zero on pe_in/pe_weight (zero padding).
REQ-026 pe_in, pe_weight, pe_bias SHALL be driven only from registers, stable throughout EVAL and HOLD.
REQ-027 EVAL lasts exactly one cycle; at its end r_data <= pe_out, r_valid <= 1, -> HOLD.
REQ-028 Latency: r_valid rises 2 cycles after the cycle of the accepted final beat.
REQ-029 HOLD: r_valid, r_data, r_trunc held until r_ready; on r_valid && r_ready all slots, pe_bias, index, r_trunc cleared, r_valid <= 0 -> IDLE.
REQ-030 No new beat accepted in the cycle the result is consumed; next beat accepted earliest one cycle later, in IDLE.
REQ-031 Elements forwarded bit-exact, no arithmetic; negative zero (sign=1, magnitude=0) passed unchanged.
REQ-032 Index width ceil(log2(N_IN)) bits; never exceeds N_IN-1.

Reset
REQ-033 rst_n low SHALL asynchronously force state IDLE, index 0, all slots 0, pe_bias 0, r_data 0, r_valid 0, r_trunc 0; s_ready reads 1 and busy 0 after reset.
REQ-034 Reset asserted mid-LOAD, EVAL or HOLD SHALL discard the partial vector or pending result; no r_valid after release until a new vector completes.

Structure
REQ-035 Shared package SHALL hold N_IN, DW defaults and the FSM state enumeration (IDLE, LOAD, EVAL, HOLD).
REQ-036 No sub-module; PE stays external and connects through pe_in/pe_weight/pe_bias/pe_out.

Verification
REQ-037 Beats (act,wgt) = (0x64,0x85),(0x5D,0x04),(0xE7,0x83),(0xFF,0x02) with s_last on 4th, s_bias=0x64 -> pe_in low 32 bits 0xFFE75D64, pe_weight low 32 bits 0x02830485, upper 464 bits 0, pe_bias 0x64; stub pe_out=0x7F -> r_data 0x7F, r_trunc 0, 2 cycles after last beat.
REQ-038 Single beat (0x00,0x00) with s_last, s_bias 0x00 -> pe_in/pe_weight all zero, r_valid 2 cycles later, r_data = stub value.
REQ-039 62 beats, s_last never asserted -> EVAL after 62nd beat, r_trunc 1, s_ready 0 until result consumed.
REQ-040 r_ready held 0 for 10 cycles in HOLD -> r_valid, r_data, pe_in stable; r_ready 1 -> next cycle IDLE, pe_in all zero.
REQ-041 rst_n pulsed low after 3 of 5 beats -> all outputs at reset values immediately; following 2-beat vector produces pe_in with slots 2..61 zero.
REQ-042 s_valid toggling randomly during LOAD -> only handshaken beats stored, in order.
